// File: rtl/uart_tx_pkg.sv
// Shared constants and types for the bus-attached UART transmitter.
// Register offsets are relative to the peripheral's base address.
package uart_tx_pkg;

   localparam logic [1:0] REG_TXDATA = 2'd0;
   localparam logic [1:0] REG_STATUS = 2'd1;
   localparam logic [1:0] REG_CTRL   = 2'd2;

   localparam int STAT_BUSY      = 0;
   localparam int STAT_FULL      = 1;
   localparam int STAT_EMPTY     = 2;
   localparam int STAT_OVERRUN   = 3;
   localparam int STAT_COUNT_LSB = 4;

   localparam int CTRL_TX_EN  = 0;
   localparam int CTRL_IRQ_EN = 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous FIFO holding bytes queued for transmission.
// The head entry is visible on dout without a read cycle so the FSM can pop and load in one edge.
module uart_tx_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     srst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_reg;
   logic [AW-1:0]    rd_ptr_reg;
   logic [AW:0]      count_reg;
   logic             do_push;
   logic             do_pop;

   // A push into a full queue is dropped even when a pop happens on the same edge.
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr_reg] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

   assign dout  = mem[rd_ptr_reg];
   assign full  = (count_reg == (AW+1)'(DEPTH));
   assign empty = (count_reg == '0);
   assign count = count_reg;

endmodule

// File: rtl/uart_tx_bus.sv
// Bus-attached 8N1 UART transmitter: register window decode, TX queue, serialiser FSM
// and a drain interrupt that is held until the processor acknowledges it.
module uart_tx_bus
   import uart_tx_pkg::*;
#(
   parameter logic [7:0] BASE_ADDR    = 8'hB0,
   parameter int         CLKS_PER_BIT = 434,
   parameter int         FIFO_DEPTH   = 4
) (
   input  logic       CLK,
   input  logic       RESET,
   inout  wire  [7:0] BUS_DATA,
   input  logic [7:0] BUS_ADDR,
   input  logic       BUS_WE,
   output logic       SEND_INTERRUPT,
   input  logic       INTERRUPT_ACK,
   output logic       TX_OUT
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   tx_state_t   state_reg, state_next;
   logic [15:0] baud_reg, baud_next;
   logic [2:0]  bit_idx_reg, bit_next;
   logic [7:0]  shift_reg, shift_next;
   logic        tx_reg, tx_next;
   logic [1:0]  ctrl_reg;
   logic        overrun_reg;
   logic        irq_reg;
   logic [7:0]  read_data_reg, read_data_next;
   logic        drive_reg;

   logic [7:0]  offset;
   logic        in_window;
   logic        wr_txdata, wr_ctrl, rd_en, rd_status;
   logic        fifo_pop, fifo_full, fifo_empty;
   logic [7:0]  fifo_dout;
   logic [CW-1:0] fifo_count;
   logic [4:0]  count_ext;
   logic [7:0]  status;
   logic        bit_end;
   logic        irq_event;

   // Window match by subtraction so the base need not be 4-byte aligned.
   assign offset    = BUS_ADDR - BASE_ADDR;
   assign in_window = (offset < 8'd4);
   assign wr_txdata = BUS_WE && in_window && (offset[1:0] == REG_TXDATA);
   assign wr_ctrl   = BUS_WE && in_window && (offset[1:0] == REG_CTRL);
   assign rd_en     = !BUS_WE && in_window;
   assign rd_status = rd_en && (offset[1:0] == REG_STATUS);

   uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
      .clk   (CLK),
      .srst  (RESET),
      .push  (wr_txdata),
      .pop   (fifo_pop),
      .din   (BUS_DATA),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign count_ext = 5'(fifo_count);

   always_comb begin
      status                 = '0;
      status[STAT_BUSY]      = (state_reg != IDLE);
      status[STAT_FULL]      = fifo_full;
      status[STAT_EMPTY]     = fifo_empty;
      status[STAT_OVERRUN]   = overrun_reg;
      status[STAT_COUNT_LSB +: 3] = (count_ext > 5'd7) ? 3'd7 : count_ext[2:0];
   end

   always_comb begin
      read_data_next = '0;
      case (offset[1:0])
         REG_STATUS: read_data_next = status;
         REG_CTRL:   read_data_next = {6'b0, ctrl_reg};
         default:    read_data_next = '0;
      endcase
   end

   assign bit_end = (baud_reg == 16'(CLKS_PER_BIT - 1));

   always_comb begin
      state_next = state_reg;
      baud_next  = baud_reg;
      bit_next   = bit_idx_reg;
      shift_next = shift_reg;
      tx_next    = tx_reg;
      fifo_pop   = 1'b0;
      irq_event  = 1'b0;
      case (state_reg)
         IDLE: begin
            tx_next = 1'b1;
            if (ctrl_reg[CTRL_TX_EN] && !fifo_empty) begin
               fifo_pop   = 1'b1;
               shift_next = fifo_dout;
               baud_next  = '0;
               bit_next   = '0;
               state_next = START;
               tx_next    = 1'b0;
            end
         end
         START: begin
            if (bit_end) begin
               baud_next  = '0;
               state_next = DATA;
               tx_next    = shift_reg[0];
            end else begin
               baud_next = baud_reg + 16'd1;
            end
         end
         DATA: begin
            // The shift register moves right so the next bit is always at [1].
            if (bit_end) begin
               baud_next = '0;
               if (bit_idx_reg == 3'd7) begin
                  bit_next   = '0;
                  state_next = STOP;
                  tx_next    = 1'b1;
               end else begin
                  bit_next   = bit_idx_reg + 3'd1;
                  shift_next = {1'b0, shift_reg[7:1]};
                  tx_next    = shift_reg[1];
               end
            end else begin
               baud_next = baud_reg + 16'd1;
            end
         end
         STOP: begin
            if (bit_end) begin
               baud_next  = '0;
               state_next = IDLE;
               irq_event  = fifo_empty && ctrl_reg[CTRL_IRQ_EN];
            end else begin
               baud_next = baud_reg + 16'd1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_reg     <= IDLE;
         baud_reg      <= '0;
         bit_idx_reg   <= '0;
         shift_reg     <= '0;
         tx_reg        <= 1'b1;
         ctrl_reg      <= '0;
         overrun_reg   <= 1'b0;
         irq_reg       <= 1'b0;
         read_data_reg <= '0;
         drive_reg     <= 1'b0;
      end else begin
         state_reg     <= state_next;
         baud_reg      <= baud_next;
         bit_idx_reg   <= bit_next;
         shift_reg     <= shift_next;
         tx_reg        <= tx_next;
         read_data_reg <= read_data_next;
         drive_reg     <= rd_en;
         if (wr_ctrl) begin
            ctrl_reg <= BUS_DATA[1:0];
         end
         if (wr_txdata && fifo_full) begin
            overrun_reg <= 1'b1;
         end else if (rd_status) begin
            overrun_reg <= 1'b0;
         end
         // A new event wins over a simultaneous acknowledge.
         if (irq_event) begin
            irq_reg <= 1'b1;
         end else if (INTERRUPT_ACK && ctrl_reg[CTRL_IRQ_EN]) begin
            irq_reg <= 1'b0;
         end
      end
   end

   assign BUS_DATA       = drive_reg ? read_data_reg : 8'bz;
   assign SEND_INTERRUPT = irq_reg;
   assign TX_OUT         = tx_reg;

endmodule
